// File: rtl/serial_arith_defs.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the bit-counter width rule.
package serial_arith_defs;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The counter must reach width-1, so it needs $clog2(width) bits (at least one).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of a bit-serial adder. The requester drives start/a/b.
// The adder returns sum/carry together with its busy/done status.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  sum, carry, busy, done
    );

    modport slave (
        input  start, a, b,
        output sum, carry, busy, done
    );
endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-adder stages plus an OR; combinational.
// Zero latency; no handshake.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    assign s1   = a ^ b;
    assign c1   = a & b;
    assign s    = s1 ^ cin;
    assign c2   = s1 & cin;
    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first; the result appears WIDTH cycles after an accepted start.
// A start is taken only while idle; starts seen while busy are dropped, not queued.
module serial_adder
    import serial_arith_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_s;
    logic             bit_c;

    full_adder_cell u_fa (
        .a    (sr_a[0]),
        .b    (sr_b[0]),
        .cin  (c),
        .s    (bit_s),
        .cout (bit_c)
    );

    // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    if (WIDTH == 1) begin : g_res_w1
        assign res_next = bit_s;
    end else begin : g_res_wn
        assign res_next = {bit_s, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sr_a    <= '0;
            sr_b    <= '0;
            res     <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sr_a   <= bus.a;
                        sr_b   <= bus.b;
                        res    <= '0;
                        c      <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sr_a <= sr_a >> 1;
                    sr_b <= sr_b >> 1;
                    res  <= res_next;
                    c    <= bit_c;
                    // sum/carry are only touched here so a partial result is never visible.
                    if (cnt == LAST) begin
                        sum_q   <= res_next;
                        carry_q <= bit_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios and a
// 1-bit instance for the minimum-width case.
module tb_serial_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic pulse_start(input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        bus8.a     = aa;
        bus8.b     = bb;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    // Entered on the falling edge right after the accepting edge; returns the
    // number of cycles until done, how many samples showed busy, and whether
    // sum/carry held their old value throughout the run.
    task automatic wait_done8(input logic [7:0] hold_sum, input logic hold_carry,
                              output int cyc, output int busy_cnt, output bit held);
        cyc      = 0;
        busy_cnt = 0;
        held     = 1'b1;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            if (bus8.busy === 1'b1) busy_cnt++;
            if (bus8.sum !== hold_sum || bus8.carry !== hold_carry) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus8.sum !== 8'h00 || bus8.carry !== 1'b0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL reset8: sum=%h carry=%b busy=%b done=%b, want all zero",
                     bus8.sum, bus8.carry, bus8.busy, bus8.done);
        end
        checks++;
        if (bus1.sum !== 1'b0 || bus1.carry !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL reset1: sum=%b carry=%b busy=%b done=%b, want all zero",
                     bus1.sum, bus1.carry, bus1.busy, bus1.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", bus8.busy, bus8.done);
        end
    endtask

    task automatic test_basic();
        int cyc, bc; bit held;
        pulse_start(8'h3C, 8'h05);
        wait_done8(8'h00, 1'b0, cyc, bc, held);
        checks++;
        if (cyc != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", cyc); end
        checks++;
        if (bc != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        checks++;
        if (!held) begin errors++; $display("FAIL basic_hold: sum/carry changed during run, want held at 00/0"); end
        checks++;
        if (bus8.sum !== 8'h41 || bus8.carry !== 1'b0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: sum=%h carry=%b busy=%b want 41 0 0", bus8.sum, bus8.carry, bus8.busy);
        end
        @(negedge clk);
        checks++;
        if (bus8.done !== 1'b0 || bus8.sum !== 8'h41) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b sum=%h want 0 41", bus8.done, bus8.sum);
        end
    endtask

    task automatic test_carry();
        int cyc, bc; bit held;
        pulse_start(8'hFF, 8'h01);
        wait_done8(8'h41, 1'b0, cyc, bc, held);
        checks++;
        if (cyc != 8 || !held || bus8.sum !== 8'h00 || bus8.carry !== 1'b1) begin
            errors++;
            $display("FAIL carry_ff_01: cyc=%0d held=%0d sum=%h carry=%b want 8 1 00 1",
                     cyc, held, bus8.sum, bus8.carry);
        end
        pulse_start(8'hFF, 8'hFF);
        wait_done8(8'h00, 1'b1, cyc, bc, held);
        checks++;
        if (cyc != 8 || !held || bus8.sum !== 8'hFE || bus8.carry !== 1'b1) begin
            errors++;
            $display("FAIL carry_ff_ff: cyc=%0d held=%0d sum=%h carry=%b want 8 1 FE 1",
                     cyc, held, bus8.sum, bus8.carry);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; bit held;
        @(negedge clk);
        bus8.a = 8'h81; bus8.b = 8'h80; bus8.start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bus8.busy); end
        cyc = 0;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            if (cyc == 3) begin bus8.a = 8'hAA; bus8.b = 8'h55; end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 8 || bus8.sum !== 8'h01 || bus8.carry !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: cyc=%0d sum=%h carry=%b want 8 01 1", cyc, bus8.sum, bus8.carry);
        end
        @(negedge clk);
        bus8.start = 1'b0;
        checks++;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b want 1 0", bus8.busy, bus8.done);
        end
        wait_done8(8'h01, 1'b1, cyc, bc, held);
        checks++;
        if (cyc != 8 || !held || bus8.sum !== 8'hFF || bus8.carry !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: cyc=%0d held=%0d sum=%h carry=%b want 8 1 FF 0",
                     cyc, held, bus8.sum, bus8.carry);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc; bit held; bit clean;
        pulse_start(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.sum !== 8'h00 || bus8.carry !== 1'b0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: sum=%h carry=%b busy=%b done=%b want 00 0 0 0",
                     bus8.sum, bus8.carry, bus8.busy, bus8.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clean = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) clean = 1'b0;
        end
        checks++;
        if (!clean) begin errors++; $display("FAIL midrun_no_done: saw done or busy after abort, want none"); end
        pulse_start(8'h12, 8'h34);
        wait_done8(8'h00, 1'b0, cyc, bc, held);
        checks++;
        if (cyc != 8 || bus8.sum !== 8'h46 || bus8.carry !== 1'b0) begin
            errors++;
            $display("FAIL midrun_next: cyc=%0d sum=%h carry=%b want 8 46 0", cyc, bus8.sum, bus8.carry);
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus8.sum !== 8'h46 || bus8.carry !== 1'b0 || bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold[%0d]: sum=%h carry=%b done=%b busy=%b want 46 0 0 0",
                         i, bus8.sum, bus8.carry, bus8.done, bus8.busy);
            end
        end
    endtask

    task automatic test_width1();
        @(negedge clk);
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        checks++;
        if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL w1_busy: busy=%b done=%b want 1 0", bus1.busy, bus1.done);
        end
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b1 || bus1.sum !== 1'b0 || bus1.carry !== 1'b1 || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL w1_result: done=%b sum=%b carry=%b busy=%b want 1 0 1 0",
                     bus1.done, bus1.sum, bus1.carry, bus1.busy);
        end
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b0 || bus1.sum !== 1'b0 || bus1.carry !== 1'b1) begin
            errors++;
            $display("FAIL w1_pulse: done=%b sum=%b carry=%b want 0 0 1", bus1.done, bus1.sum, bus1.carry);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid_run();
        test_idle_hold();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end
endmodule
